// File: rtl/crc32_pkg.sv
// Shared constants, FSM state type and the single-bit CRC-32 step used by
// the FIFO reader and its optional byte-wide unrolled datapath.
package crc32_pkg;

    localparam int unsigned CRC_W     = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [CRC_W-1:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [CRC_W-1:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_XOROUT = 32'hFFFFFFFF;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // One LSB-first step of the reflected CRC-32 shift register.
    function automatic logic [CRC_W-1:0] crc32_bit_step(
        input logic [CRC_W-1:0] crc,
        input logic             din,
        input logic [CRC_W-1:0] poly = CRC32_POLY
    );
        return (crc >> 1) ^ (((crc[0] ^ din) == 1'b1) ? poly : '0);
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational fold of one byte into the CRC: eight chained bit-steps.
// Only instantiated when CRC32_BYTE_UNROLL_EN is defined.
module crc32_byte_step
    import crc32_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC32_POLY
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] acc;

    always_comb begin
        acc = crc_in;
        for (int i = 0; i < BYTE_W; i++) begin
            acc = crc32_bit_step(acc, data[i], POLY);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc32_fifo_reader.sv
// Read-side consumer of the FWFT byte FIFO: pops bytes and folds them into a
// running CRC-32. Define CRC32_BYTE_UNROLL_EN for a 1 byte/cycle datapath.
module crc32_fifo_reader
    import crc32_pkg::*;
#(
    parameter int unsigned      CNT_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC32_POLY,
    parameter logic [CRC_W-1:0] INIT  = CRC32_INIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [BYTE_W-1:0] fifo_dout,
    input  logic [3:0]        fifo_count,
    output logic              fifo_done,
    output logic [CRC_W-1:0]  crc_value,
    output logic              busy,
    output logic [CNT_W-1:0]  byte_cnt
);

    state_t            state;
    logic [CRC_W-1:0]  crc_reg;
    logic [BYTE_W-1:0] sh_reg;
    logic [CRC_W-1:0]  crc_next;
    logic              last;
    logic              take;

`ifdef CRC32_BYTE_UNROLL_EN
    // Whole byte folded in the single SHIFT cycle.
    crc32_byte_step #(.POLY(POLY)) u_byte_step (
        .crc_in  (crc_reg),
        .data    (sh_reg),
        .crc_out (crc_next)
    );

    assign last = (state == ST_SHIFT);
`else
    logic [BIT_CNT_W-1:0] bit_cnt;

    assign crc_next = crc32_bit_step(crc_reg, sh_reg[0], POLY);
    assign last     = (state == ST_SHIFT) && (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
`endif

    // Pop only when idle or on the final shift, so a new byte chains with no gap.
    assign take = enable && !clear && (fifo_count != 4'd0) &&
                  ((state == ST_IDLE) || last);

    assign fifo_done = take;
    assign crc_value = crc_reg ^ CRC32_XOROUT;
    assign busy      = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            crc_reg  <= INIT;
            sh_reg   <= '0;
            byte_cnt <= '0;
`ifndef CRC32_BYTE_UNROLL_EN
            bit_cnt  <= '0;
`endif
        end else if (clear) begin
            // An in-flight byte is dropped without being counted.
            state    <= ST_IDLE;
            crc_reg  <= INIT;
            byte_cnt <= '0;
`ifndef CRC32_BYTE_UNROLL_EN
            bit_cnt  <= '0;
`endif
        end else begin
            if (state == ST_SHIFT) begin
                crc_reg <= crc_next;
`ifndef CRC32_BYTE_UNROLL_EN
                sh_reg  <= sh_reg >> 1;
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
`endif
                if (last) begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end

            if (take) begin
                sh_reg <= fifo_dout;
                state  <= ST_SHIFT;
`ifndef CRC32_BYTE_UNROLL_EN
                bit_cnt <= '0;
`endif
            end else if (last) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_crc32_fifo_reader.sv
// Directed bench for crc32_fifo_reader with a behavioural 8-entry FWFT FIFO.
module tb_crc32_fifo_reader;

`ifdef CRC32_BYTE_UNROLL_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  fifo_dout;
    logic [3:0]  fifo_count;
    logic        fifo_done;
    logic [31:0] crc_value;
    logic        busy;
    logic [15:0] byte_cnt;

    logic        push = 1'b0;
    logic [7:0]  push_data = 8'h00;
    logic [7:0]  fmem [8] = '{default: 8'h00};
    logic [2:0]  rp = 3'd0;
    logic [2:0]  wp = 3'd0;
    logic [3:0]  cnt = 4'd0;

    int          cyc = 0;
    int          pops = 0;
    int          pop_cyc [64];
    logic        empty_pop = 1'b0;

    int          checks = 0;
    int          errors = 0;

    crc32_fifo_reader #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clear      (clear),
        .fifo_dout  (fifo_dout),
        .fifo_count (fifo_count),
        .fifo_done  (fifo_done),
        .crc_value  (crc_value),
        .busy       (busy),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_dout  = fmem[rp];
    assign fifo_count = cnt;

    // FWFT FIFO model plus pop bookkeeping.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_done) begin
            if (pops < 64) pop_cyc[pops] <= cyc;
            pops <= pops + 1;
            if (cnt == 4'd0) empty_pop <= 1'b1;
        end
        if (!rst_n) begin
            rp  <= 3'd0;
            wp  <= 3'd0;
            cnt <= 4'd0;
        end else begin
            if (push && cnt != 4'd8) begin
                fmem[wp] <= push_data;
                wp       <= wp + 3'd1;
            end
            if (fifo_done && cnt != 4'd0) rp <= rp + 3'd1;
            cnt <= cnt + 4'((push && cnt != 4'd8) ? 1 : 0)
                       - 4'((fifo_done && cnt != 4'd0) ? 1 : 0);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        push      = 1'b1;
        push_data = b;
        @(negedge clk);
        push      = 1'b0;
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((fifo_count != 4'd0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for idle, count=%0d busy=%b", tag, fifo_count, busy);
        end
    endtask

    task automatic wait_pops(input int target, input string tag);
        int n;
        n = 0;
        while (pops < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for pop %0d, got %0d", tag, target, pops);
        end
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (crc_value !== 32'h0) begin errors++; $display("FAIL reset_crc: got %h want 00000000", crc_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", byte_cnt); end
        checks++; if (fifo_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", fifo_done); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (crc_value !== 32'h0) begin errors++; $display("FAIL idle_crc: got %h want 00000000", crc_value); end
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL idle_cnt: got %0d want 0", byte_cnt); end
        checks++; if (pops !== 0) begin errors++; $display("FAIL idle_pops: got %0d want 0", pops); end
    endtask

    task automatic test_check_string();
        int start;
        logic bad;
        enable = 1'b0;
        clear_pulse();
        for (int i = 0; i < 8; i++) push_byte(8'h31 + 8'(i));
        start = pops;
        @(negedge clk);
        enable = 1'b1;
        push_byte(8'h39);
        wait_idle("string");
        checks++; if (pops - start !== 9) begin errors++; $display("FAIL string_pops: got %0d want 9", pops - start); end
        bad = 1'b0;
        for (int i = 1; i < 9; i++) begin
            if (pop_cyc[start + i] - pop_cyc[start + i - 1] != GAP) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL string_spacing: pop gaps not %0d cycles", GAP); end
        checks++; if (crc_value !== 32'hCBF43926) begin errors++; $display("FAIL string_crc: got %h want cbf43926", crc_value); end
        checks++; if (byte_cnt !== 16'd9) begin errors++; $display("FAIL string_cnt: got %0d want 9", byte_cnt); end
    endtask

    task automatic test_single_byte();
        enable = 1'b1;
        clear_pulse();
        push_byte(8'h00);
        wait_idle("zero");
        checks++; if (crc_value !== 32'hD202EF8D) begin errors++; $display("FAIL zero_crc: got %h want d202ef8d", crc_value); end
        checks++; if (byte_cnt !== 16'd1) begin errors++; $display("FAIL zero_cnt: got %0d want 1", byte_cnt); end
        clear_pulse();
        checks++; if (crc_value !== 32'h0) begin errors++; $display("FAIL clear_crc: got %h want 00000000", crc_value); end
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL clear_cnt: got %0d want 0", byte_cnt); end
        push_byte(8'h61);
        wait_idle("a");
        checks++; if (crc_value !== 32'hE8B7BE43) begin errors++; $display("FAIL a_crc: got %h want e8b7be43", crc_value); end
        checks++; if (byte_cnt !== 16'd1) begin errors++; $display("FAIL a_cnt: got %0d want 1", byte_cnt); end
    endtask

    task automatic test_full_fifo();
        int start;
        enable = 1'b0;
        clear_pulse();
        start = pops;
        for (int i = 0; i < 8; i++) push_byte(8'h41 + 8'(i));
        repeat (4) @(negedge clk);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", fifo_count); end
        checks++; if (pops - start !== 0) begin errors++; $display("FAIL full_nopop: got %0d want 0", pops - start); end
        enable = 1'b1;
        wait_idle("drain");
        checks++; if (pops - start !== 8) begin errors++; $display("FAIL drain_pops: got %0d want 8", pops - start); end
        repeat (10) @(negedge clk);
        checks++; if (pops - start !== 8) begin errors++; $display("FAIL empty_pops: got %0d want 8", pops - start); end
        checks++; if (byte_cnt !== 16'd8) begin errors++; $display("FAIL drain_cnt: got %0d want 8", byte_cnt); end
    endtask

    task automatic test_clear_midbyte();
        int start;
        enable = 1'b0;
        clear_pulse();
        push_byte(8'h31);
        push_byte(8'h32);
        start = pops;
        @(negedge clk);
        enable = 1'b1;
        wait_pops(start + 2, "clr_second_pop");
        wait_cyc(pop_cyc[start + 1] + 5);
        checks++; if (byte_cnt !== 16'd1) begin errors++; $display("FAIL clr_pre_cnt: got %0d want 1", byte_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy: got %b want 1", busy); end
        clear = 1'b1;
        #1;
        checks++; if (fifo_done !== 1'b0) begin errors++; $display("FAIL clr_nopop: got %b want 0", fifo_done); end
        @(negedge clk);
        clear = 1'b0;
        checks++; if (crc_value !== 32'h0) begin errors++; $display("FAIL clr_crc: got %h want 00000000", crc_value); end
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", byte_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
        push_byte(8'h61);
        wait_idle("clr_restart");
        checks++; if (crc_value !== 32'hE8B7BE43) begin errors++; $display("FAIL clr_restart_crc: got %h want e8b7be43", crc_value); end
        checks++; if (byte_cnt !== 16'd1) begin errors++; $display("FAIL clr_restart_cnt: got %0d want 1", byte_cnt); end
    endtask

    task automatic test_enable_drop();
        int start;
        enable = 1'b0;
        clear_pulse();
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        start = pops;
        @(negedge clk);
        enable = 1'b1;
        wait_pops(start + 1, "en_first_pop");
        wait_cyc(pop_cyc[start] + 4);
        enable = 1'b0;
        repeat (16) @(negedge clk);
        checks++; if (byte_cnt !== 16'd1) begin errors++; $display("FAIL en_cnt: got %0d want 1", byte_cnt); end
        checks++; if (pops - start !== 1) begin errors++; $display("FAIL en_pops: got %0d want 1", pops - start); end
        checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL en_count: got %0d want 2", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy: got %b want 0", busy); end
        enable = 1'b1;
        wait_idle("en_resume");
        checks++; if (byte_cnt !== 16'd3) begin errors++; $display("FAIL en_resume_cnt: got %0d want 3", byte_cnt); end
    endtask

    initial begin
        test_reset();
        test_check_string();
        test_single_byte();
        test_full_fifo();
        test_clear_midbyte();
        test_enable_drop();
        checks++; if (empty_pop !== 1'b0) begin errors++; $display("FAIL empty_pop: got %b want 0", empty_pop); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc32_fifo_reader.md
Name: crc32_fifo_reader

Overview:
- Read-side consumer for the 8-entry first-word-fall-through (FWFT) byte FIFO in the CRC32 peripheral.
- Pops one byte whenever the FIFO is non-empty and folds it into a running CRC-32. Algorithm: reflected, poly 0xEDB88320, init 0xFFFFFFFF, xorout 0xFFFFFFFF.
- Default datapath is bit-serial at 8 cycles/byte. Exposes the CRC value, a busy flag and a byte counter to the register interface.

Parameters:
- CNT_W, 16, width of the processed-byte counter.
- POLY, 32'hEDB88320, reflected CRC-32 polynomial.
- INIT, 32'hFFFFFFFF, CRC register value after reset or clear.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  allows new bytes to be popped; an in-flight byte always completes.
- clear  input  1  synchronous re-init of the CRC and counter; aborts any in-flight byte.
- fifo_dout  input  8  FIFO head byte, valid whenever fifo_count != 0.
- fifo_count  input  4  FIFO occupancy, 0..8.
- fifo_done  output  1  combinational pop strobe to the FIFO; FIFO advances at the same edge.
- crc_value  output  32  current CRC, equal to ~crc_reg.
- busy  output  1  high while a byte is being shifted.
- byte_cnt  output  CNT_W  bytes fully folded since reset or clear.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, crc_reg=INIT, byte_cnt=0, bit_cnt=0.
  - Outputs: crc_value=0x00000000, busy=0, fifo_done=0.
- take = enable && !clear && (fifo_count != 0) && (state==IDLE || (state==SHIFT && bit_cnt==7)).
- fifo_done = take. It is never asserted when fifo_count==0. It is at most one cycle high per byte.
- On take: sh_reg <= fifo_dout, bit_cnt <= 0, state <= SHIFT. The byte is sampled at the same edge the FIFO advances.
- SHIFT cycle: fb = crc_reg[0] ^ sh_reg[0]; crc_reg <= (crc_reg>>1) ^ (fb ? POLY : 0); sh_reg <= sh_reg>>1 (LSB first); bit_cnt++.
- Completing a byte (SHIFT with bit_cnt==7):
  - byte_cnt increments, wrapping mod 2^CNT_W.
  - If take, the next byte is loaded with no gap, giving exactly 8 cycles/byte sustained.
  - Otherwise state returns to IDLE.
- busy = (state==SHIFT).
- Latency: crc_value reflects a byte 8 cycles after its fifo_done edge, i.e. on the cycle after the 8th SHIFT edge.
- clear: priority over everything except reset.
  - crc_reg=INIT, byte_cnt=0, state=IDLE, no pop that cycle.
  - A byte already popped and in flight is discarded and not counted.
- enable deasserted mid-byte: the current byte finishes; no further pop.
- Full FIFO (count=8): no special case; the consumer drains it normally.
- Empty FIFO: stays in, or returns to, IDLE; crc_value holds.
- The FIFO may be written during SHIFT. fifo_count changes are only sampled in take-eligible cycles.

Optional Feature:
- Macro: CRC32_BYTE_UNROLL_EN.
- Defined:
  - SHIFT is a single cycle: all 8 bit-steps are computed combinationally and registered at once. bit_cnt is unused and treated as always last.
  - Throughput is 1 byte/cycle, with back-to-back pops while the FIFO is non-empty.
  - busy is high for the single cycle after each pop.
- Undefined: bit-serial operation at 8 cycles/byte as above.
- Final CRC values must be identical in both builds.

Decomposition:
- Package crc32_pkg:
  - Constants CRC32_POLY, CRC32_INIT, CRC32_XOROUT.
  - State enum {ST_IDLE, ST_SHIFT}.
  - Function crc32_bit_step(crc, bit) returning the next crc.
- Sub-module crc32_byte_step: combinational, 8 chained bit-steps. Used only under CRC32_BYTE_UNROLL_EN.

Test Plan:
- Reset, no FIFO writes, enable=1 for 20 cycles -> crc_value=0x00000000, byte_cnt=0, fifo_done never high.
- Push "123456789" (0x31..0x39) via the FIFO, enable=1 -> exactly 9 fifo_done pulses, spaced 8 cycles apart (1 cycle under UNROLL); final crc_value=0xCBF43926, byte_cnt=9.
- Single byte 0x00 -> crc_value=0xD202EF8D. Then clear, then single byte 0x61 -> crc_value=0xE8B7BE43, byte_cnt=1.
- Fill the FIFO to 8 with enable=0 -> no pops, count stays 8. Then raise enable -> drains to 0 with 8 pops, and 0 pops after empty.
- Assert clear at bit_cnt=4 of the second byte of "12" -> crc_value=0x00000000, byte_cnt=0, state IDLE; no pop in the clear cycle; the next byte restarts from INIT.
- Drop enable at bit_cnt=3 with 2 bytes remaining in the FIFO -> the current byte completes (byte_cnt increments), no further fifo_done, and fifo_count stays 2.
